// File: rtl/auth_request_scheduler_if.sv
// Request/engine/driver signal bundle of the auth request scheduler.
// slave = scheduler side, master = request source, engine and driver side.
interface auth_request_scheduler_if;
    logic [7:0] pending_auth_request;
    logic       req_load;
    logic       PD_in_ready;
    logic       DEBUG_in_ready;
    logic       auth_msg_ready;
    logic       eng_start;
    logic [1:0] eng_code;
    logic [1:0] eng_slot;
    logic       eng_path;
    logic       Ack_in_driver;
    logic       req_reject;
    logic [3:0] slot_done;
    logic [3:0] slot_fail;
    logic       sched_busy;

    modport slave (
        input  pending_auth_request, req_load, PD_in_ready, DEBUG_in_ready, auth_msg_ready,
        output eng_start, eng_code, eng_slot, eng_path, Ack_in_driver, req_reject,
               slot_done, slot_fail, sched_busy
    );

    modport master (
        output pending_auth_request, req_load, PD_in_ready, DEBUG_in_ready, auth_msg_ready,
        input  eng_start, eng_code, eng_slot, eng_path, Ack_in_driver, req_reject,
               slot_done, slot_fail, sched_busy
    );
endinterface

// File: rtl/auth_request_scheduler.sv
// Round-robin sequencer of four auth request slots onto one engine; load-to-start 3 cycles, response-to-ack 1.
// Waits indefinitely for a ready PD/DEBUG path; engine responses time out with bounded re-issue.
module auth_request_scheduler #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_RETRY      = 2,
    parameter int TW             = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    auth_request_scheduler_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_WAIT_PATH, S_ISSUE, S_WAIT_RESP, S_ACK
    } state_e;

    localparam int             RW        = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0]  RETRY_MAX = RW'(MAX_RETRY);

    state_e            state_q, state_d;
    logic [3:0][1:0]   slot_q, slot_d;
    logic [1:0]        rr_q, rr_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic [1:0]        code_q, code_d;
    logic [1:0]        eslot_q, eslot_d;
    logic              path_q, path_d;
    logic [3:0]        done_q, done_d;
    logic [3:0]        fail_q, fail_d;
    logic              reject_q, reject_d;

    logic              found;
    logic [1:0]        pick;
    logic [1:0]        cand;

    // First occupied slot at or after the round-robin pointer, wrapping mod 4.
    always_comb begin
        found = 1'b0;
        pick  = rr_q;
        cand  = rr_q;
        for (int k = 0; k < 4; k++) begin
            cand = rr_q + 2'(k);
            if (!found && slot_q[cand] != 2'b00) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        rr_d     = rr_q;
        timer_d  = timer_q;
        retry_d  = retry_q;
        code_d   = code_q;
        eslot_d  = eslot_q;
        path_d   = path_q;
        done_d   = done_q;
        fail_d   = fail_q;
        reject_d = bus.req_load && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (bus.req_load) begin
                    slot_d  = bus.pending_auth_request;
                    done_d  = '0;
                    fail_d  = '0;
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (found) begin
                    eslot_d = pick;
                    code_d  = slot_q[pick];
                    retry_d = '0;
                    state_d = S_WAIT_PATH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_PATH: begin
                if (bus.PD_in_ready) begin
                    path_d  = 1'b0;
                    state_d = S_ISSUE;
                end else if (bus.DEBUG_in_ready) begin
                    path_d  = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT_RESP;
            end
            S_WAIT_RESP: begin
                timer_d = timer_q + 1'b1;
                // A response arriving on the timeout cycle still counts as success.
                if (bus.auth_msg_ready) begin
                    state_d = S_ACK;
                end else if (timer_q == TMO_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_WAIT_PATH;
                    end else begin
                        fail_d[eslot_q] = 1'b1;
                        slot_d[eslot_q] = 2'b00;
                        rr_d            = eslot_q + 2'd1;
                        state_d         = S_SELECT;
                    end
                end
            end
            S_ACK: begin
                done_d[eslot_q] = 1'b1;
                slot_d[eslot_q] = 2'b00;
                rr_d            = eslot_q + 2'd1;
                state_d         = S_SELECT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            slot_q   <= '0;
            rr_q     <= '0;
            timer_q  <= '0;
            retry_q  <= '0;
            code_q   <= '0;
            eslot_q  <= '0;
            path_q   <= 1'b0;
            done_q   <= '0;
            fail_q   <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            rr_q     <= rr_d;
            timer_q  <= timer_d;
            retry_q  <= retry_d;
            code_q   <= code_d;
            eslot_q  <= eslot_d;
            path_q   <= path_d;
            done_q   <= done_d;
            fail_q   <= fail_d;
            reject_q <= reject_d;
        end
    end

    assign bus.eng_start     = (state_q == S_ISSUE);
    assign bus.Ack_in_driver = (state_q == S_ACK);
    assign bus.sched_busy    = (state_q != S_IDLE);
    assign bus.eng_code      = code_q;
    assign bus.eng_slot      = eslot_q;
    assign bus.eng_path      = path_q;
    assign bus.req_reject    = reject_q;
    assign bus.slot_done     = done_q;
    assign bus.slot_fail     = fail_q;

endmodule

// File: doc/auth_request_scheduler.md
Name: auth_request_scheduler

Overview:
- Sequences pending USB Type-C authentication requests onto the single shared authentication message engine.
- Holds four 2-bit request slots loaded from pending_auth_request and serves them in round-robin order.
- Per request, picks the PD or DEBUG transport path, issues a start strobe, waits for the engine response with a timeout and bounded retries, then acknowledges the driver.
- Sits between the host-side request source and the auth message engine / PD_DEBUG driver.

Parameters:
- TIMEOUT_CYCLES, 1024: WAIT_RESP cycles before a timeout; must be at least 2.
- MAX_RETRY, 2: re-issues allowed after the first timeout before the slot fails.
- TW, 11: timer width; must satisfy 2^TW > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- pending_auth_request  in  8  four request codes; slot i = bits [2i+1:2i]. Codes: 00 none, 01 GET_DIGESTS, 10 GET_CERTIFICATE, 11 CHALLENGE.
- req_load  in  1  one-cycle strobe to load pending_auth_request into the slot table.
- PD_in_ready  in  1  PD transport path can accept a message.
- DEBUG_in_ready  in  1  DEBUG transport path can accept a message.
- auth_msg_ready  in  1  engine response available for the issued request.
- eng_start  out  1  one-cycle issue strobe to the engine.
- eng_code  out  2  request code of the slot in service.
- eng_slot  out  2  index of the slot in service.
- eng_path  out  1  0 = PD, 1 = DEBUG; latched in WAIT_PATH.
- Ack_in_driver  out  1  one-cycle acknowledge after a response is consumed.
- req_reject  out  1  one-cycle pulse when req_load arrives outside IDLE.
- slot_done  out  4  sticky per-slot completion flags.
- slot_fail  out  4  sticky per-slot failure flags (retries exhausted).
- sched_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state = IDLE, slot table = 0, rr_ptr = 0, timer = 0, retry count = 0. All outputs are 0.
- States: IDLE, SELECT, WAIT_PATH, ISSUE, WAIT_RESP, ACK. Outputs are Moore, decoded from registered state, except req_reject.
- IDLE:
  - req_load = 1: copy pending_auth_request into the slot table; clear slot_done and slot_fail; go to SELECT next cycle.
  - A load of all-zero codes passes through SELECT and returns to IDLE.
- req_load in any non-IDLE state: ignored; slot table unchanged; req_reject = 1 in the following cycle.
- SELECT:
  - Scan slots rr_ptr, rr_ptr+1, ... (mod 4) for the first nonzero code.
  - Found: capture eng_slot and eng_code, clear retry count, go to WAIT_PATH.
  - None found: go to IDLE.
  - SELECT takes exactly 1 cycle.
- WAIT_PATH:
  - PD_in_ready = 1: eng_path = 0, go to ISSUE.
  - Else DEBUG_in_ready = 1: eng_path = 1, go to ISSUE.
  - Neither ready: stay, with no timeout.
  - If both are ready, PD wins.
- ISSUE: eng_start = 1 for exactly this cycle; timer cleared; go to WAIT_RESP.
- WAIT_RESP:
  - Timer increments every cycle.
  - auth_msg_ready = 1: go to ACK.
  - Else timer == TIMEOUT_CYCLES-1:
    - retry count < MAX_RETRY: increment retry count, go to WAIT_PATH.
    - Otherwise: set slot_fail[eng_slot], clear that slot's code, rr_ptr = eng_slot+1 (mod 4), go to SELECT.
  - auth_msg_ready and timeout in the same cycle: the response wins, no retry.
  - auth_msg_ready outside WAIT_RESP is ignored.
- ACK:
  - Ack_in_driver = 1 for one cycle.
  - Set slot_done[eng_slot]; clear that slot's code; rr_ptr = eng_slot+1 (mod 4); go to SELECT.
- Latency with a ready path:
  - req_load sampled in cycle t: SELECT at t+1, WAIT_PATH at t+2, eng_start at t+3.
  - auth_msg_ready in cycle r: Ack_in_driver in cycle r+1.
  - Next eng_start in cycle r+4.
- eng_code, eng_slot and eng_path stay stable from SELECT/WAIT_PATH through ACK.
- sched_busy = (state != IDLE).
- reset mid-operation: return to IDLE the next cycle with the full reset state, including the slot table and sticky flags.

Test Plan:
- Round-robin order: reset, PD_in_ready = 1, load 8'b01100011, engine answers 5 cycles after each eng_start.
  - Required: three eng_start pulses with (slot, code) = (0,11), (2,10), (3,01); never slot 1.
  - Required: Ack_in_driver after each; final slot_done = 4'b1101, slot_fail = 0; return to IDLE.
- Path selection: load 8'b00000001.
  - PD = 0, DEBUG = 0 for 10 cycles: stays in WAIT_PATH, eng_start = 0.
  - Then DEBUG = 1: eng_start with eng_path = 1.
  - Repeat with both ready: eng_path = 0.
- Timeout and retry: TIMEOUT_CYCLES = 8, MAX_RETRY = 2, load 8'b00000010, never assert auth_msg_ready.
  - Required: exactly 3 eng_start pulses, spaced 8 (WAIT_RESP) + 1 (WAIT_PATH) + 1 (ISSUE) = 10 cycles apart.
  - Required: slot_fail = 4'b0001, Ack_in_driver never high, IDLE at the end.
- Race: auth_msg_ready asserted exactly on timer == TIMEOUT_CYCLES-1 → Ack_in_driver asserted, no retry, slot_done bit set.
- Reject: req_load while in WAIT_RESP → req_reject pulse the next cycle; slot table and ongoing sequence unaffected.
- Reset mid-operation: reset = 1 for 1 cycle during WAIT_RESP.
  - Required: the next cycle shows all outputs 0 and state IDLE.
  - A late auth_msg_ready produces no Ack_in_driver.
